// File: rtl/response_misr_checker_if.sv
// rtl/response_misr_checker_if.sv - stimulus/response bus between driver and MISR checker
interface response_misr_checker_if #(
  parameter int Y_WIDTH   = 245,
  parameter int SIG_WIDTH = 32,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic [CNT_WIDTH-1:0] expected_count;
  logic [SIG_WIDTH-1:0] golden_sig;
  logic                 y_valid;
  logic [Y_WIDTH-1:0]   y;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 overrun;
  logic [SIG_WIDTH-1:0] signature;
  logic [CNT_WIDTH-1:0] sample_count;

  modport master (
    output start, expected_count, golden_sig, y_valid, y,
    input  busy, done, pass, overrun, signature, sample_count
  );

  modport slave (
    input  start, expected_count, golden_sig, y_valid, y,
    output busy, done, pass, overrun, signature, sample_count
  );
endinterface

// File: rtl/response_misr_checker.sv
// rtl/response_misr_checker.sv - folds a wide response bus into a MISR and checks it against a golden signature
module response_misr_checker #(
  parameter int                   Y_WIDTH   = 245,
  parameter int                   SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED      = 32'h00000000,
  parameter int                   CNT_WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  response_misr_checker_if.slave bus
);

  localparam int NCHUNK    = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int EXT_WIDTH = NCHUNK * SIG_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] exp_q, exp_d;
  logic [SIG_WIDTH-1:0] golden_q, golden_d;
  logic                 pass_q, pass_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [EXT_WIDTH-1:0] y_ext;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] misr_next;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Zero-extend y to a whole number of chunks, then XOR all chunks together.
  always_comb begin
    y_ext              = '0;
    y_ext[Y_WIDTH-1:0] = bus.y;
    fold               = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      fold = fold ^ y_ext[i*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold;
  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    golden_d  = golden_q;
    pass_d    = pass_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE, DONE: begin
        // start takes priority over a coincident y_valid, which is dropped.
        if (bus.start) begin
          sig_d     = SEED;
          cnt_d     = '0;
          overrun_d = 1'b0;
          pass_d    = 1'b0;
          golden_d  = bus.golden_sig;
          exp_d     = bus.expected_count;
          state_d   = (bus.expected_count == '0) ? COMPARE : CAPTURE;
        end else if (state_q == DONE && bus.y_valid) begin
          overrun_d = 1'b1;
        end
      end
      CAPTURE: begin
        if (bus.y_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          if (cnt_inc == exp_q) begin
            state_d = COMPARE;
          end
        end
      end
      COMPARE: begin
        pass_d  = (sig_q == golden_q);
        state_d = DONE;
        if (bus.y_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE) || (state_d == COMPARE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sig_q     <= SEED;
      cnt_q     <= '0;
      exp_q     <= '0;
      golden_q  <= '0;
      pass_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      golden_q  <= golden_d;
      pass_q    <= pass_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.overrun      = overrun_q;
  assign bus.signature    = sig_q;
  assign bus.sample_count = cnt_q;

endmodule

// File: tb/tb_response_misr_checker.sv
// tb/tb_response_misr_checker.sv - self-checking bench for response_misr_checker
module tb_response_misr_checker;

  localparam int          YW   = 245;
  localparam int          SW   = 32;
  localparam int          CW   = 8;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  response_misr_checker_if #(.Y_WIDTH(YW), .SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  response_misr_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [31:0]   golden;
    logic [31:0]   sig1;
    logic [31:0]   sig2;
    logic          pass;
  } vec_t;

  vec_t tbl[6];

  // Reference: bit i of y lands in signature bit (i mod 32); then one MISR clock.
  function automatic logic [31:0] m_fold(input logic [YW-1:0] v);
    logic [31:0] f = '0;
    for (int i = 0; i < YW; i++) f[i % 32] = f[i % 32] ^ v[i];
    return f;
  endfunction

  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [YW-1:0] v);
    logic [32:0] wide = {s, 1'b0};
    if (wide[32]) wide[31:0] = wide[31:0] ^ POLY;
    return wide[31:0] ^ m_fold(v);
  endfunction

  function automatic logic [YW-1:0] rand_y();
    logic [255:0] t = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
    return t[YW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] cnt, input logic [31:0] g);
    bus.start          = 1'b1;
    bus.expected_count = cnt;
    bus.golden_sig     = g;
    step();
    bus.start          = 1'b0;
    bus.expected_count = 8'($urandom);
    bus.golden_sig     = $urandom;
  endtask

  task automatic put(input logic [YW-1:0] v, input logic vld);
    bus.y       = v;
    bus.y_valid = vld;
    step();
    bus.y_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " sig"},     64'(bus.signature),    64'h0);
    chk({tag, " count"},   64'(bus.sample_count), 64'h0);
    chk({tag, " busy"},    64'(bus.busy),         64'h0);
    chk({tag, " done"},    64'(bus.done),         64'h0);
    chk({tag, " pass"},    64'(bus.pass),         64'h0);
    chk({tag, " overrun"}, 64'(bus.overrun),      64'h0);
  endtask

  initial begin
    logic [YW-1:0] yv;
    logic [31:0]   model;
    logic [31:0]   g;
    logic [YW-1:0] ys[$];
    int            cnt;
    logic          gap[5];
    int            gap_cnt[5];

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.start = 1'b0; bus.expected_count = '0; bus.golden_sig = '0;
    bus.y_valid = 1'b0; bus.y = '0;

    tbl[0] = '{y0: 245'h1, y1: 245'h1, golden: 32'h3,
               sig1: 32'h1, sig2: 32'h3, pass: 1'b1};
    tbl[1] = '{y0: 245'h1_00000001, y1: 245'h0, golden: 32'h0,
               sig1: 32'h0, sig2: 32'h0, pass: 1'b1};
    tbl[2] = '{y0: 245'h80000000, y1: 245'h0, golden: 32'h04C11DB7,
               sig1: 32'h80000000, sig2: 32'h04C11DB7, pass: 1'b1};
    tbl[3] = '{y0: 245'h0, y1: 245'h0, golden: 32'h0,
               sig1: 32'h00100000, sig2: 32'h00200000, pass: 1'b0};
    tbl[3].y0 = 245'h1 << 244;
    tbl[4] = '{y0: 245'h0000FFFF_FFFFFFFF, y1: 245'h0, golden: 32'hFB3F1DB7,
               sig1: 32'hFFFF0000, sig2: 32'hFB3F1DB7, pass: 1'b1};
    tbl[5] = '{y0: '1, y1: 245'h1, golden: 32'h12345678,
               sig1: 32'hFFE00000, sig2: 32'hFB011DB6, pass: 1'b0};

    for (int i = 0; i < 3; i++) begin
      bus.y_valid = ~bus.y_valid;
      bus.y = rand_y();
      step();
    end
    chk_reset_vals("reset");
    rst_n = 1'b1;
    bus.y_valid = 1'b0;
    put(rand_y(), 1'b1);
    chk("idle valid count", 64'(bus.sample_count), 64'h0);

    // Two-sample vector table
    for (int i = 0; i < 6; i++) begin
      do_start(8'd2, tbl[i].golden);
      chk($sformatf("tbl%0d busy", i), 64'(bus.busy), 64'h1);
      put(tbl[i].y0, 1'b1);
      chk($sformatf("tbl%0d sig1", i), 64'(bus.signature), 64'(tbl[i].sig1));
      put(tbl[i].y1, 1'b1);
      chk($sformatf("tbl%0d sig2", i), 64'(bus.signature), 64'(tbl[i].sig2));
      chk($sformatf("tbl%0d compare busy", i), 64'(bus.busy), 64'h1);
      chk($sformatf("tbl%0d early done", i), 64'(bus.done), 64'h0);
      step();
      chk($sformatf("tbl%0d done", i), 64'(bus.done), 64'h1);
      chk($sformatf("tbl%0d pass", i), 64'(bus.pass), 64'(tbl[i].pass));
      chk($sformatf("tbl%0d idle busy", i), 64'(bus.busy), 64'h0);
    end

    // Gapped run with a wrong golden
    gap = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    gap_cnt = '{1, 1, 1, 2, 3};
    model = 32'h0;
    do_start(8'd3, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      yv = rand_y();
      if (gap[i]) model = m_step(model, yv);
      put(yv, gap[i]);
      chk($sformatf("gap count %0d", i), 64'(bus.sample_count), 64'(gap_cnt[i]));
      chk($sformatf("gap sig %0d", i), 64'(bus.signature), 64'(model));
    end
    step();
    chk("gap done", 64'(bus.done), 64'h1);
    chk("gap pass", 64'(bus.pass), 64'(model == 32'hDEADBEEF));

    // Overrun in DONE, then start colliding with y_valid
    put(rand_y(), 1'b1);
    chk("overrun set", 64'(bus.overrun), 64'h1);
    chk("overrun count hold", 64'(bus.sample_count), 64'h3);
    chk("overrun sig hold", 64'(bus.signature), 64'(model));
    bus.start = 1'b1; bus.expected_count = 8'd1; bus.golden_sig = 32'h0;
    bus.y = 245'h1; bus.y_valid = 1'b1;
    step();
    bus.start = 1'b0; bus.y_valid = 1'b0;
    chk("restart overrun", 64'(bus.overrun), 64'h0);
    chk("restart count", 64'(bus.sample_count), 64'h0);
    chk("restart sig", 64'(bus.signature), 64'h0);
    chk("restart done", 64'(bus.done), 64'h0);
    put(245'h1, 1'b1);
    chk("one sample sig", 64'(bus.signature), 64'h1);
    put(245'h5, 1'b1);
    chk("compare overrun", 64'(bus.overrun), 64'h1);
    chk("compare sig hold", 64'(bus.signature), 64'h1);
    chk("compare done", 64'(bus.done), 64'h1);
    chk("compare pass", 64'(bus.pass), 64'h0);

    // Full-scale run: 255 samples, golden taken from the model
    ys.delete();
    model = 32'h0;
    for (int i = 0; i < 255; i++) begin
      ys.push_back(rand_y());
      model = m_step(model, ys[i]);
    end
    do_start(8'd255, model);
    foreach (ys[i]) put(ys[i], 1'b1);
    chk("max count", 64'(bus.sample_count), 64'd255);
    chk("max busy", 64'(bus.busy), 64'h1);
    step();
    chk("max done", 64'(bus.done), 64'h1);
    chk("max pass", 64'(bus.pass), 64'h1);
    chk("max sig", 64'(bus.signature), 64'(model));

    // Randomised runs with gaps; inputs scrambled after start
    for (int r = 0; r < 20; r++) begin
      cnt = $urandom_range(1, 8);
      ys.delete();
      model = 32'h0;
      for (int i = 0; i < cnt; i++) begin
        ys.push_back(rand_y());
        model = m_step(model, ys[i]);
      end
      g = ($urandom_range(0, 1) == 1) ? model : $urandom;
      do_start(8'(cnt), g);
      model = 32'h0;
      for (int i = 0; i < cnt; i++) begin
        while ($urandom_range(0, 2) == 0) put(rand_y(), 1'b0);
        model = m_step(model, ys[i]);
        put(ys[i], 1'b1);
        chk($sformatf("rnd%0d sig %0d", r, i), 64'(bus.signature), 64'(model));
        chk($sformatf("rnd%0d count %0d", r, i), 64'(bus.sample_count), 64'(i + 1));
      end
      step();
      chk($sformatf("rnd%0d done", r), 64'(bus.done), 64'h1);
      chk($sformatf("rnd%0d pass", r), 64'(bus.pass), 64'(model == g));
    end

    // Mid-run reset, then zero-length runs
    do_start(8'd4, 32'h0);
    put(245'h7, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async reset");
    step();
    rst_n = 1'b1;
    step();
    chk("post reset done", 64'(bus.done), 64'h0);
    do_start(8'd0, 32'h0);
    chk("zero busy", 64'(bus.busy), 64'h1);
    chk("zero early done", 64'(bus.done), 64'h0);
    step();
    chk("zero done", 64'(bus.done), 64'h1);
    chk("zero pass", 64'(bus.pass), 64'h1);
    do_start(8'd0, 32'h1);
    step();
    chk("zero done mism", 64'(bus.done), 64'h1);
    chk("zero pass mism", 64'(bus.pass), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/response_misr_checker.md
Name: response_misr_checker

Overview:
- Receiving end of the stimulus/strobe interface. The testbench drives input vectors into `top` and samples the 245-bit `y` on every rising clock edge.
- This block performs that sampling in synthesizable form. It XOR-folds each valid `y` sample into a multiple-input signature register (MISR) and counts the samples.
- After the expected number of samples, it compares the signature against a golden value and reports pass/fail.
- Used in self-checking simulation and on-chip so that two result streams can be compared without any $strobe text diffing.

Parameters:
- Y_WIDTH, 245: width of the monitored response bus (bits 244:0).
- SIG_WIDTH, 32: signature width.
- POLY, 32'h04C11DB7: Galois feedback polynomial for the MISR.
- SEED, 32'h00000000: signature value loaded on start.
- CNT_WIDTH, 8: width of the sample counter and the expected-count input.

Ports:
- clk  input  1  Single clock; all state updates on posedge.
- rst_n  input  1  Reset, asynchronous assert, active-low.
- start  input  1  One-cycle pulse; begins a run. Honoured in IDLE and DONE only.
- expected_count  input  CNT_WIDTH  Number of samples in the run. Latched when start is accepted.
- golden_sig  input  SIG_WIDTH  Reference signature. Latched when start is accepted.
- y_valid  input  1  Qualifies y for the current cycle.
- y  input  Y_WIDTH  Response bus under observation.
- busy  output  1  High in CAPTURE and COMPARE.
- done  output  1  High in DONE; holds until the next accepted start.
- pass  output  1  Registered result of signature == golden; meaningful only while done is high.
- overrun  output  1  Sticky flag: y_valid seen in COMPARE or DONE. Cleared by an accepted start.
- signature  output  SIG_WIDTH  Current MISR value.
- sample_count  output  CNT_WIDTH  Samples absorbed in the current run.

Behaviour:
- Reset (asynchronous, active-low) forces the following; all are registered outputs:
  - state = IDLE
  - signature = SEED
  - sample_count = 0
  - busy, done, pass, overrun = 0
  - latched golden and expected values = 0
- Fold function:
  - y is zero-extended to ceil(Y_WIDTH/SIG_WIDTH)*SIG_WIDTH bits (256 bits at the defaults).
  - All SIG_WIDTH-bit chunks are XORed together to give `fold`.
- MISR update:
  - next = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold.
- FSM states:
  - IDLE:
    - start: load SEED, clear count, clear overrun, latch golden_sig and expected_count.
    - Go to CAPTURE, or to COMPARE directly if expected_count == 0.
  - CAPTURE:
    - Each cycle with y_valid = 1, the MISR updates and sample_count increments.
    - When the update brings sample_count to the latched expected count, go to COMPARE on the next edge.
    - Cycles with y_valid = 0 hold all state.
    - start is ignored.
  - COMPARE:
    - Single cycle; registers pass = (signature == latched golden).
    - Go to DONE.
  - DONE:
    - done = 1 and pass is stable.
    - start restarts exactly as from IDLE; done drops on the same edge.
- Latency:
  - Final valid sample accepted at edge N: state is COMPARE after edge N, and done/pass are visible after edge N+1.
  - Minimum run time with expected_count = 0 is start at edge S, done visible after edge S+1.
- Boundaries:
  - Counter never wraps; the run ends at expected_count ≤ 2^CNT_WIDTH-1.
  - start and y_valid in the same cycle while in IDLE or DONE: start wins, and that sample is not absorbed.
  - y_valid in COMPARE or DONE: sample not absorbed; overrun is set.
  - Reset mid-run aborts immediately with no done pulse.
  - Changes to golden_sig or expected_count after start have no effect.

Test Plan:
- Reset then idle: rst_n low with y_valid toggling -> signature = 0, sample_count = 0, done = 0, busy = 0, overrun = 0.
- Two-sample run:
  - Stimulus: SEED 0, expected_count = 2, y = 1 for 2 valid cycles, golden_sig = 32'h00000003.
  - Required: signature 1 then 3; done after N+1 with pass = 1.
- Fold cancellation and feedback:
  - Stimulus: y with bits 0 and 32 set -> fold = 0, signature stays 0.
  - Stimulus: preload signature 32'h80000000 via one sample y = 32'h80000000, then sample y = 0.
  - Required: signature = 32'h04C11DB7.
- Mismatch with gaps:
  - Stimulus: expected_count = 3, y_valid gapped (1,0,0,1,1), golden wrong.
  - Required: sample_count reaches 3 only on valid cycles; done = 1, pass = 0.
- Overrun and restart:
  - Stimulus: extra y_valid in DONE -> overrun = 1.
  - Stimulus: start in same cycle as y_valid.
  - Required: overrun clears, sample not absorbed, count = 0.
- Mid-run reset:
  - Stimulus: assert rst_n low after 1 of 4 samples.
  - Required: all outputs return to reset values asynchronously; subsequent start with expected_count = 0 gives done with pass = (SEED == golden).
